// File: rtl/mac_job_controller.sv
// Job sequencer for the shared MAC datapath: sync start, clear, run TAPS terms, drain, capture.
// Optional MACJOB_ERR_ABORT_EN adds the ERR state so datapath faults abort the job.
module mac_job_controller #(
    parameter int TAPS    = 8,
    parameter int TAW     = 3,
    parameter int ACCW    = 20,
    parameter int MAC_LAT = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       c_select,
    input  logic [ACCW-1:0]  acc_in,
    input  logic             err_mac,
    input  logic             err_mult,
    output logic [TAW+1:0]   coef_addr,
    output logic [TAW-1:0]   samp_addr,
    output logic             mac_clr,
    output logic             mac_en,
    output logic             busy,
    output logic [ACCW-1:0]  result,
    output logic             result_valid,
    output logic             err_flag,
    output logic [7:0]       led
);

    typedef enum logic [2:0] {S_IDLE, S_CLEAR, S_RUN, S_WAIT, S_DONE, S_ERR} state_t;

    state_t          state_q, state_d;
    logic [2:0]      sync_q, sync_d;
    logic [TAW-1:0]  tap_q, tap_d;
    logic [2:0]      lat_q, lat_d;
    logic [1:0]      set_q, set_d;
    logic [ACCW-1:0] result_q, result_d;
    logic [7:0]      led_q, led_d;
    logic            err_flag_q, err_flag_d;
    logic            req;
    logic            unused_err;

    assign unused_err = err_mac | err_mult;

    // sync_q = {s3, s2, s1}; a request is the rising edge seen between s2 and s3
    assign req = sync_q[1] & ~sync_q[2];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            sync_q     <= '0;
            tap_q      <= '0;
            lat_q      <= '0;
            set_q      <= '0;
            result_q   <= '0;
            led_q      <= '0;
            err_flag_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            sync_q     <= sync_d;
            tap_q      <= tap_d;
            lat_q      <= lat_d;
            set_q      <= set_d;
            result_q   <= result_d;
            led_q      <= led_d;
            err_flag_q <= err_flag_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        sync_d       = {sync_q[1:0], start};
        tap_d        = tap_q;
        lat_d        = lat_q;
        set_d        = set_q;
        result_d     = result_q;
        led_d        = led_q;
        err_flag_d   = err_flag_q;
        mac_clr      = 1'b0;
        mac_en       = 1'b0;
        result_valid = 1'b0;
        coef_addr    = '0;
        samp_addr    = '0;

        case (state_q)
            S_IDLE: begin
                if (req) begin
                    set_d      = c_select;
                    err_flag_d = 1'b0;
                    state_d    = S_CLEAR;
                end
            end
            S_CLEAR: begin
                mac_clr = 1'b1;
                tap_d   = '0;
                state_d = S_RUN;
            end
            S_RUN: begin
                mac_en    = 1'b1;
                coef_addr = {set_q, tap_q};
                samp_addr = tap_q;
                tap_d     = tap_q + TAW'(1);
                if (tap_q == TAW'(TAPS - 1)) begin
                    lat_d   = 3'(MAC_LAT);
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                lat_d = lat_q - 3'd1;
                if (lat_q <= 3'd1) state_d = S_DONE;
            end
            S_DONE: begin
                result_valid = 1'b1;
                state_d      = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

`ifdef MACJOB_ERR_ABORT_EN
        // a fault wins over the WAIT->DONE transition on the same edge
        if ((state_q == S_RUN || state_q == S_WAIT) && (err_mac || err_mult)) begin
            state_d = S_ERR;
            tap_d   = '0;
            lat_d   = '0;
        end
        if (state_d == S_ERR) begin
            err_flag_d = 1'b1;
            led_d      = 8'hFF;
        end
`endif

        // capture on the edge entering DONE so result and result_valid coincide
        if (state_d == S_DONE && state_q == S_WAIT) begin
            result_d = acc_in;
            led_d    = acc_in[7:0];
        end
    end

    assign busy   = (state_q != S_IDLE);
    assign result = result_q;
    assign led    = led_q;
`ifdef MACJOB_ERR_ABORT_EN
    assign err_flag = err_flag_q;
`else
    assign err_flag = 1'b0;
`endif

endmodule

// File: tb/tb_mac_job_controller.sv
// Scoreboard bench for mac_job_controller with a behavioural MAC, coefficient ROM and sample buffer.
module tb_mac_job_controller;
    localparam int TAPS = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic [1:0]  c_select = 2'b00;
    logic [19:0] acc_in;
    logic        err_mac = 1'b0;
    logic        err_mult = 1'b0;
    logic [4:0]  coef_addr;
    logic [2:0]  samp_addr;
    logic        mac_clr, mac_en, busy, result_valid, err_flag;
    logic [19:0] result;
    logic [7:0]  led;

    int errors = 0;
    int checks = 0;
    int rv_count = 0;
    int coef [0:31];
    int samp [0:7];
    logic [19:0] exp_q[$];
    logic [31:0] acc = 0;

    mac_job_controller dut (
        .clk(clk), .rst(rst), .start(start), .c_select(c_select), .acc_in(acc_in),
        .err_mac(err_mac), .err_mult(err_mult), .coef_addr(coef_addr), .samp_addr(samp_addr),
        .mac_clr(mac_clr), .mac_en(mac_en), .busy(busy), .result(result),
        .result_valid(result_valid), .err_flag(err_flag), .led(led)
    );

    always #5 clk = ~clk;

    // behavioural MAC driven by the DUT's own addresses
    always @(posedge clk) begin
        if (mac_clr) acc <= 0;
        else if (mac_en) acc <= acc + 32'(coef[coef_addr] * samp[samp_addr]);
    end
    assign acc_in = acc[19:0];

    function automatic logic [19:0] exp_sum(input logic [1:0] sel);
        int s = 0;
        for (int t = 0; t < TAPS; t++) s += coef[{sel, 3'(t)}] * samp[t];
        return 20'(s);
    endfunction

    always @(negedge clk) begin
        if (rst && result_valid) begin
            logic [19:0] e;
            rv_count++;
            if (exp_q.size() == 0) begin
                errors++; checks++;
                $display("FAIL unexpected_result_valid: got result=%h want no pulse", result);
            end else begin
                e = exp_q.pop_front();
                checks += 2;
                if (result !== e) begin
                    errors++; $display("FAIL result: got %h want %h", result, e);
                end
                if (led !== e[7:0]) begin
                    errors++; $display("FAIL led: got %h want %h", led, e[7:0]);
                end
            end
        end
    end

    task automatic start_job(input logic [1:0] sel);
        c_select = sel;
        exp_q.push_back(exp_sum(sel));
        start = 1'b1;
    endtask

    // follows one job from the negedge start was raised; E0 is the first edge after
    task automatic watch_job(input logic [1:0] sel, input bit toggle, input int hold, input bit repulse);
        int clr_at = -1, rv_at = -1, en_n = 0;
        bit addr_bad = 0;
        for (int e = 0; e < 40 && rv_at < 0; e++) begin
            @(negedge clk);
            if (hold > 0 && e == hold - 1) start = 1'b0;
            if (repulse && e == 5) start = 1'b1;
            if (repulse && e == 7) start = 1'b0;
            if (toggle && e >= 3) c_select = c_select + 2'd1;
            if (mac_clr && clr_at < 0) clr_at = e;
            if (mac_en) begin
                if (coef_addr !== {sel, 3'(en_n)} || samp_addr !== 3'(en_n)) addr_bad = 1;
                en_n++;
            end
            if (result_valid) rv_at = e;
        end
        checks += 4;
        if (clr_at !== 2) begin errors++; $display("FAIL clr_timing: got %0d want 2", clr_at); end
        if (en_n !== TAPS) begin errors++; $display("FAIL mac_en_cycles: got %0d want %0d", en_n, TAPS); end
        if (addr_bad) begin errors++; $display("FAIL addr_seq: got bad address want set %0d taps 0..7", sel); end
        if (rv_at !== 13) begin errors++; $display("FAIL rv_timing: got %0d want 13", rv_at); end
        @(negedge clk);
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        checks++;
        if ({busy, mac_clr, mac_en, result_valid, err_flag, result, led, coef_addr, samp_addr} !== '0) begin
            errors++; $display("FAIL reset_state: got busy=%b result=%h led=%h want all zero", busy, result, led);
        end
        rst = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            checks++;
            if ({busy, mac_clr, mac_en, result_valid, err_flag, result, led, coef_addr, samp_addr} !== '0) begin
                errors++; $display("FAIL idle_quiet: cycle %0d got busy=%b led=%h want zero", i, busy, led);
            end
        end
    endtask

    task automatic test_basic();
        start_job(2'b01);
        watch_job(2'b01, 0, 2, 0);
        checks += 2;
        if (result !== 20'h00123) begin errors++; $display("FAIL basic_result: got %h want 00123", result); end
        if (led !== 8'h23) begin errors++; $display("FAIL basic_led: got %h want 23", led); end
    endtask

    task automatic test_hold_and_drop();
        int rv0 = rv_count;
        start_job(2'b00);
        watch_job(2'b00, 0, 0, 0);
        repeat (100) @(negedge clk);
        checks++;
        if (rv_count !== rv0 + 1) begin errors++; $display("FAIL held_start_jobs: got %0d want 1", rv_count - rv0); end
        start = 1'b0;
        repeat (5) @(negedge clk);
        rv0 = rv_count;
        start_job(2'b11);
        watch_job(2'b11, 0, 2, 1);
        repeat (20) @(negedge clk);
        checks += 2;
        if (rv_count !== rv0 + 1) begin errors++; $display("FAIL busy_pulse_dropped: got %0d jobs want 1", rv_count - rv0); end
        if (busy !== 1'b0) begin errors++; $display("FAIL idle_after_drop: got busy=%b want 0", busy); end
    endtask

    task automatic test_select_toggle();
        start_job(2'b10);
        watch_job(2'b10, 1, 2, 0);
    endtask

    task automatic test_reset_mid_run();
        int rv0;
        logic [19:0] dropped;
        start_job(2'b10);
        for (int e = 0; e <= 6; e++) begin
            @(negedge clk);
            if (e == 1) start = 1'b0;
        end
        rst = 1'b0;
        dropped = exp_q.pop_back();
        #1;
        checks++;
        if ({busy, mac_en, led, result} !== '0) begin
            errors++; $display("FAIL async_reset: got busy=%b mac_en=%b led=%h want 0 (dropped %h)", busy, mac_en, led, dropped);
        end
        @(negedge clk);
        rst = 1'b1;
        rv0 = rv_count;
        repeat (20) @(negedge clk);
        checks++;
        if (rv_count !== rv0) begin errors++; $display("FAIL reset_no_valid: got %0d pulses want 0", rv_count - rv0); end
        start_job(2'b01);
        watch_job(2'b01, 0, 2, 0);
    endtask

    task automatic test_fault();
        int rv0 = rv_count;
        logic [19:0] prev = result;
        start_job(2'b11);
`ifdef MACJOB_ERR_ABORT_EN
        void'(exp_q.pop_back());
`endif
        for (int e = 0; e < 20; e++) begin
            @(negedge clk);
            if (e == 1) start = 1'b0;
            if (e == 6) err_mult = 1'b1;
            if (e == 7) begin
                err_mult = 1'b0;
`ifdef MACJOB_ERR_ABORT_EN
                checks++;
                if ({busy, err_flag, led} !== {1'b1, 1'b1, 8'hFF}) begin
                    errors++; $display("FAIL err_state: got busy=%b err_flag=%b led=%h want 1 1 ff", busy, err_flag, led);
                end
`endif
            end
        end
        checks += 3;
`ifdef MACJOB_ERR_ABORT_EN
        if (rv_count !== rv0) begin errors++; $display("FAIL err_no_valid: got %0d pulses want 0", rv_count - rv0); end
        if (err_flag !== 1'b1 || led !== 8'hFF) begin errors++; $display("FAIL err_sticky: got %b/%h want 1/ff", err_flag, led); end
        if (result !== prev) begin errors++; $display("FAIL err_result_kept: got %h want %h", result, prev); end
`else
        if (rv_count !== rv0 + 1) begin errors++; $display("FAIL fault_ignored: got %0d pulses want 1", rv_count - rv0); end
        if (err_flag !== 1'b0) begin errors++; $display("FAIL err_flag_tied: got %b want 0", err_flag); end
        if (result !== exp_sum(2'b11)) begin errors++; $display("FAIL fault_ignored_result: got %h want %h (prev %h)", result, exp_sum(2'b11), prev); end
`endif
        start_job(2'b00);
        watch_job(2'b00, 0, 2, 0);
        checks++;
        if (err_flag !== 1'b0) begin errors++; $display("FAIL err_flag_cleared: got %b want 0", err_flag); end
    endtask

    initial begin
        for (int i = 0; i < 32; i++) coef[i] = 3 * i + 1;
        for (int t = 0; t < 8; t++) begin
            samp[t] = t + 1;
            coef[8 + t] = t + 1;
        end
        coef[8] = 88;  // makes set 1 sum to 20'h00123
        test_reset();
        test_basic();
        test_hold_and_drop();
        test_select_toggle();
        test_reset_mid_run();
        test_fault();
        repeat (5) @(negedge clk);
        checks++;
        if (exp_q.size() !== 0) begin errors++; $display("FAIL scoreboard_drain: got %0d pending want 0", exp_q.size()); end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/mac_job_controller.md
# mac_job_controller

Sequencer for the NPU's shared MAC datapath. Accepts a debounced start request and a 2-bit coefficient-set select. Steps the MAC through one dot-product job of `TAPS` terms, waits out the datapath pipeline, then captures the accumulator into a result register and the LED bank. Sits between the board-level push-button/switch inputs and the MAC/multiplier datapath in the top-level NPU.

## Interface

Parameters:
- `TAPS`, 8: terms per job; must be a power of two, 2..16.
- `TAW`, 3: tap address width, log2(`TAPS`).
- `ACCW`, 20: accumulator/result width.
- `MAC_LAT`, 2: cycles from last `mac_en` until `acc_in` is final; range 1..7.

Ports:
- `clk` in 1: system clock, rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `start` in 1: asynchronous level from button; rising edge requests a job.
- `c_select` in 2: coefficient set, sampled when a start is accepted.
- `acc_in` in `ACCW`: accumulator value from the MAC datapath.
- `err_mac` in 1: MAC datapath fault indication.
- `err_mult` in 1: multiplier fault indication.
- `coef_addr` out 2+`TAW`: `{set, tap}` coefficient ROM address.
- `samp_addr` out `TAW`: sample buffer address.
- `mac_clr` out 1: clear accumulator.
- `mac_en` out 1: accumulate the current term.
- `busy` out 1: job in progress.
- `result` out `ACCW`: last completed job result.
- `result_valid` out 1: one-cycle pulse when `result` updates.
- `err_flag` out 1: last job aborted (only meaningful with `MACJOB_ERR_ABORT_EN`).
- `led` out 8: display.

## Operation

- **Start path:**
  - `start` passes through a 2-flop synchronizer (s1, s2) plus a history flop s3.
  - A request is `s2 & ~s3`.
  - A request is accepted only in IDLE. Requests in any other state are dropped, not queued.
- **On accept:**
  - Latch `c_select` into `set`.
  - Clear `err_flag`.
- **States:**
  - **IDLE:** `busy`=0. Accept → CLEAR.
  - **CLEAR:** one cycle. `mac_clr`=1, tap counter=0. → RUN.
  - **RUN:** `TAPS` cycles. `mac_en`=1, `coef_addr`={`set`, tap}, `samp_addr`=tap, tap increments each cycle. The tap counter wraps to 0 after `TAPS`-1 → WAIT.
  - **WAIT:** `MAC_LAT` cycles, counted by a separate 3-bit down-counter. `mac_en`=0. → DONE.
  - **DONE:** one cycle. `result`<=`acc_in`, `led`<=`acc_in[7:0]`, `result_valid`=1. → IDLE.
  - **ERR** (only with `MACJOB_ERR_ABORT_EN`): one cycle. `err_flag`<=1, `led`<=8'hFF, `result` unchanged, no `result_valid`. → IDLE.
- `busy`=1 in CLEAR, RUN, WAIT, DONE and ERR.
- Addresses hold 0 outside RUN.
- `result` and `led` hold their values between jobs.
- `c_select` changes during a job have no effect.
- `start` held high produces exactly one request. A new job requires `start` to go low and then high again.

## Timing

- Reset values:
  - State IDLE, all counters 0, s1/s2/s3 0.
  - `mac_clr`, `mac_en`, `busy`, `result_valid`, `err_flag` = 0.
  - `result`=0, `led`=0, addresses 0.
- Reset mid-job aborts immediately to IDLE with the reset values above; no `result_valid` is produced.
- Latency: `start` is sampled high at edge E0. The request is visible after E1, and the state becomes CLEAR after E2.
  - RUN occupies the cycles after E3..E(2+`TAPS`).
  - DONE follows E(3+`TAPS`+`MAC_LAT`).
  - Defaults: `result_valid` high in the cycle after E13.
  - Job length from CLEAR to DONE inclusive is `TAPS`+`MAC_LAT`+2 cycles.
- Fault sampling (with the macro): `err_mac|err_mult` is sampled on each edge while in RUN or WAIT. A fault moves the FSM to ERR on the next edge. A fault on the same edge that would enter DONE takes priority, so the FSM goes to ERR.

## Configuration

- `MACJOB_ERR_ABORT_EN` defined:
  - The ERR state exists.
  - Faults abort the job as described in Operation and Timing.
  - `err_flag` is sticky until the next accepted start.
- `MACJOB_ERR_ABORT_EN` undefined:
  - `err_mac` and `err_mult` are ignored; ports remain present.
  - ERR is unreachable.
  - `err_flag` is tied to 0.
  - Every accepted job ends in DONE.

## Test plan

1. Reset with `rst`=0, then release. With no `start`, all outputs stay 0 and `busy`=0 for 50 cycles.
2. `c_select`=2'b01; a model MAC returns the sum of products = 20'h00123. Pulse `start` → `mac_clr` for 1 cycle. `mac_en` for 8 cycles with `coef_addr` 8..15 and `samp_addr` 0..7. `result_valid` pulses 13 cycles after sync (2 cycles). `result`=20'h00123, `led`=8'h23.
3. Hold `start` high for 100 cycles → exactly one job. A second pulse of `start` during `busy` → ignored. A pulse after IDLE → a second job with `c_select`=2'b11 and addresses 24..31.
4. Toggle `c_select` every cycle during RUN → addresses use the set latched at accept only.
5. Assert `rst`=0 for 1 cycle in the middle of RUN → `busy`, `mac_en` and `led` drop to 0 asynchronously, with no `result_valid`. The next `start` runs a full, correct job.
6. With `MACJOB_ERR_ABORT_EN`, assert `err_mult`=1 on the 4th RUN cycle → ERR, `err_flag`=1, `led`=8'hFF, `result` keeps its previous value. The next start clears `err_flag`. Without the macro, the same stimulus → normal DONE.
